// File: rtl/fas_seq_ctrl.sv
// Sequencer for a FIR -> ping-pong frame buffer -> FFT pipeline.
// Counts input samples, strobes FIR results into the buffer and schedules FFT frames.
`timescale 1ns/1ps
module fas_seq_ctrl #(
  parameter int TAPS        = 32,
  parameter int FRAME_LEN   = 16,
  parameter int NUM_SAMPLES = 1024,
  localparam int AW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic          fft_busy,
  input  logic          fft_done,
  output logic          fir_shift,
  output logic          fir_valid,
  output logic          buf_wr,
  output logic [AW-1:0] buf_addr,
  output logic          buf_bank,
  output logic          fft_start,
  output logic          fft_valid,
  output logic [7:0]    frame_cnt,
  output logic          overrun,
  output logic          done,
  output logic [2:0]    state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [10:0]   TAPS_C = 11'(TAPS);
  localparam logic [10:0]   NUM_C  = 11'(NUM_SAMPLES);
  localparam logic [AW-1:0] LAST_A = AW'(FRAME_LEN - 1);

  logic [2:0]  state, state_n;
  logic [10:0] sample_cnt;
  logic [10:0] cnt_inc;
  logic        accepting, accept;
  logic        frame_done, issue_pending, start_new;
  logic        pending, in_flight, done_ok, drain_clear;

  // Handshake: data_valid is a one-cycle sample strobe with no back-pressure;
  // it is honoured only before the run length is reached, ignored afterwards.
  assign accepting = (state == S_IDLE) || (state == S_FILL) || (state == S_RUN);
  assign accept    = data_valid && accepting;
  assign cnt_inc   = sample_cnt + 11'd1;
  assign fir_shift = accept;
  assign buf_wr    = fir_valid;
  assign state_dbg = state;

  // Frame scheduling: a held frame goes out as soon as the engine is free;
  // only one frame may wait, later completions are dropped.
  assign frame_done    = fir_valid && (buf_addr == LAST_A);
  assign issue_pending = pending && !fft_busy;
  assign start_new     = frame_done && !fft_busy && !pending;
  assign done_ok       = fft_done && in_flight;
  assign drain_clear   = !pending && !fft_busy && !in_flight && !fft_start && !fir_valid;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_FILL, S_RUN: begin
        if (accept) begin
          if (cnt_inc >= NUM_C)       state_n = S_DRAIN;
          else if (cnt_inc >= TAPS_C) state_n = S_RUN;
          else                        state_n = S_FILL;
        end
      end
      S_DRAIN: if (drain_clear) state_n = S_DONE;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      fir_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_bank   <= 1'b0;
      fft_start  <= 1'b0;
      fft_valid  <= 1'b0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
      done       <= 1'b0;
      pending    <= 1'b0;
      in_flight  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && (sample_cnt != NUM_C)) sample_cnt <= cnt_inc;
      fir_valid <= accept && (cnt_inc >= TAPS_C);

      if (fir_valid) buf_addr <= (buf_addr == LAST_A) ? '0 : buf_addr + AW'(1);
      if (frame_done) buf_bank <= ~buf_bank;

      fft_start <= issue_pending || start_new;
      if (issue_pending) begin
        pending <= frame_done;
      end else if (frame_done && fft_busy) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      // A start in this cycle keeps the engine marked busy even if an
      // earlier frame's done arrives alongside it.
      if (fft_start)    in_flight <= 1'b1;
      else if (done_ok) in_flight <= 1'b0;
      fft_valid <= done_ok;
      if (done_ok && (frame_cnt != 8'hFF)) frame_cnt <= frame_cnt + 8'd1;

      if ((state == S_DRAIN) && drain_clear) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fas_seq_ctrl.sv
// Scoreboard bench for fas_seq_ctrl: stimulus pushes expected FIR writes, FFT starts
// and FFT results into queues; negedge monitors pop and compare against DUT outputs.
`timescale 1ns/1ps
module tb_fas_seq_ctrl;
  localparam int TAPS = 32;
  localparam int FRAME_LEN = 16;
  localparam int NUM_SAMPLES = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_valid = 1'b0;
  logic fft_busy = 1'b0;
  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  logic fft_done;
  logic fir_shift, fir_valid, buf_wr, buf_bank, fft_start, fft_valid, overrun, done;
  logic [3:0] buf_addr;
  logic [7:0] frame_cnt;
  logic [2:0] state_dbg;

  assign fft_done = resp_done | spur_done;

  fas_seq_ctrl #(.TAPS(TAPS), .FRAME_LEN(FRAME_LEN), .NUM_SAMPLES(NUM_SAMPLES)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .fft_busy(fft_busy), .fft_done(fft_done),
    .fir_shift(fir_shift), .fir_valid(fir_valid), .buf_wr(buf_wr), .buf_addr(buf_addr),
    .buf_bank(buf_bank), .fft_start(fft_start), .fft_valid(fft_valid), .frame_cnt(frame_cnt),
    .overrun(overrun), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [31:0] fir_q[$];
  int start_q[$], valid_q[$], comp_q[$], resp_q[$];
  int m_idx = 0;
  logic exp_shift = 1'b0;
  logic m_pend = 1'b0, m_ovr = 1'b0;
  int m_fc = 0;
  int n_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {fir_shift, fir_valid, buf_wr, buf_addr, buf_bank, fft_start, fft_valid,
                 frame_cnt, overrun, done}, 32'd0);
  endtask

  // driver: one cycle of stimulus plus the abstract sample/frame bookkeeping
  task automatic tick(input logic dv, input logic busy);
    @(posedge clk); #1;
    data_valid = dv;
    fft_busy   = busy;
    exp_shift  = dv && (m_idx < NUM_SAMPLES);
    if (exp_shift) begin
      m_idx++;
      if (m_idx >= TAPS) begin
        int w;
        w = m_idx - TAPS;
        fir_q.push_back({27'(cyc + 1), 1'((w / FRAME_LEN) % 2), 4'(w % FRAME_LEN)});
        if (w % FRAME_LEN == FRAME_LEN - 1) comp_q.push_back(cyc + 1);
      end
    end
  endtask

  task automatic clear_model();
    m_idx = 0;
    exp_shift = 1'b0;
    fir_q.delete(); start_q.delete(); valid_q.delete(); comp_q.delete();
  endtask

  // FFT engine responder: finishes each frame two cycles after its start
  always @(posedge clk) begin
    #1;
    if (rst) begin
      resp_q.delete();
      resp_done = 1'b0;
    end else begin
      if (fft_start) resp_q.push_back(cyc + 2);
      if (resp_q.size() > 0 && resp_q[0] == cyc) begin
        void'(resp_q.pop_front());
        resp_done = 1'b1;
        valid_q.push_back(cyc + 1);
      end else begin
        resp_done = 1'b0;
      end
    end
  end

  // reference model of frame scheduling: at most one waiting frame
  always @(negedge clk) begin : sched_model
    logic comp, issued;
    if (rst) begin
      m_pend = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      check("overrun_track", overrun, m_ovr);
      comp = (comp_q.size() > 0 && comp_q[0] == cyc);
      if (comp) void'(comp_q.pop_front());
      issued = 1'b0;
      if (m_pend && !fft_busy) begin
        start_q.push_back(cyc + 1);
        m_pend = 1'b0;
        issued = 1'b1;
      end
      if (comp) begin
        if (!fft_busy && !m_pend && !issued) start_q.push_back(cyc + 1);
        else if (!m_pend) m_pend = 1'b1;
        else m_ovr = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst) begin
      m_fc = 0;
    end else begin
      check("fir_shift", fir_shift, exp_shift);
      if (fir_q.size() > 0 && fir_q[0][31:5] == 27'(cyc)) begin
        e = fir_q.pop_front();
        check("fir_write", {fir_valid, buf_wr, buf_bank, buf_addr}, {2'b11, e[4:0]});
      end else if (fir_valid || buf_wr) begin
        check("unexpected_fir", {fir_valid, buf_wr}, 32'd0);
      end
      if (fft_start) n_starts++;
      if (start_q.size() > 0 && start_q[0] == cyc) begin
        void'(start_q.pop_front());
        check("fft_start", fft_start, 1'b1);
      end else if (fft_start) begin
        check("unexpected_fft_start", fft_start, 1'b0);
      end
      if (valid_q.size() > 0 && valid_q[0] == cyc) begin
        void'(valid_q.pop_front());
        check("fft_valid", fft_valid, 1'b1);
        if (m_fc < 255) m_fc++;
        check("frame_cnt", frame_cnt, m_fc);
      end else if (fft_valid) begin
        check("unexpected_fft_valid", fft_valid, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0, to;
    logic [3:0] a0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset_state");
    check("reset_fsm_idle", state_dbg, 3'd0);

    // fft_done with nothing started is ignored
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    repeat (3) tick(0, 0);
    check("spurious_done_cnt", frame_cnt, 8'd0);

    // one frame completes under busy, busy drops 5 cycles later
    tick(0, 1);
    repeat (47) tick(1, 1);
    repeat (5) tick(0, 1);
    s0 = n_starts;
    repeat (10) tick(0, 0);
    check("held_frame_starts", n_starts - s0, 1);
    check("held_frame_overrun", overrun, 1'b0);

    // two completions under busy: second is dropped
    s0 = n_starts;
    repeat (32) tick(1, 1);
    repeat (4) tick(0, 1);
    repeat (10) tick(0, 0);
    check("two_held_starts", n_starts - s0, 1);
    check("two_held_overrun", overrun, 1'b1);

    // leave a frame waiting, then reset after sample 100
    repeat (21) tick(1, 1);
    repeat (3) tick(0, 1);
    check("pre_reset_count", m_idx, 100);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    check_zero("midrun_reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("after_reset");
    s0 = n_starts;
    repeat (10) tick(0, 0);
    check("pending_lost", n_starts - s0, 0);

    // full randomized run, engine never busy
    s0 = n_starts;
    while (m_idx < NUM_SAMPLES) tick($urandom_range(0, 3) != 0, 0);
    to = 0;
    while (!done && to < 300) begin
      tick(0, 0);
      to++;
    end
    check("run_done", done, 1'b1);
    check("run_starts", n_starts - s0, 62);
    check("run_frame_cnt", frame_cnt, 8'd62);
    check("run_overrun", overrun, 1'b0);
    check("run_final_addr", buf_addr, 4'd1);
    check("run_final_bank", buf_bank, 1'b0);

    // activity after completion must change nothing
    a0 = buf_addr;
    repeat (6) tick(1, 0);
    @(posedge clk); #1 data_valid = 1'b0; spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    repeat (4) tick(0, 0);
    check("done_addr_hold", buf_addr, a0);
    check("done_cnt_hold", frame_cnt, 8'd62);
    check("done_sticky", done, 1'b1);
    check("queues_drained", fir_q.size() + start_q.size() + valid_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fas_seq_ctrl.md
FAS_SEQ_CTRL -- requirements
Module: fas_seq_ctrl

Interface
REQ-001 Parameter TAPS, default 32: FIR tap count, which sets the warm-up length.
REQ-002 Parameter FRAME_LEN, default 16: FIR samples per FFT frame; power of two.
REQ-003 Parameter NUM_SAMPLES, default 1024: input samples per run.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 data_valid  input  1  one input sample accepted per high cycle.
REQ-007 fft_busy  input  1  FFT engine is processing a frame.
REQ-008 fft_done  input  1  one-cycle pulse: FFT engine finished a frame.
REQ-009 fir_shift  output  1  delay-line shift enable.
REQ-010 fir_valid  output  1  one-cycle pulse: fir_d updated with a valid result.
REQ-011 buf_wr  output  1  frame-buffer write strobe.
REQ-012 buf_addr  output  log2(FRAME_LEN)  frame-buffer write address.
REQ-013 buf_bank  output  1  ping-pong bank currently being written.
REQ-014 fft_start  output  1  one-cycle pulse: start the FFT on bank ~buf_bank.
REQ-015 fft_valid  output  1  one-cycle pulse: FFT results valid.
REQ-016 frame_cnt  output  8  FFT frames completed.
REQ-017 overrun  output  1  sticky: a completed frame was dropped.
REQ-018 done  output  1  sticky: run complete.

Function
REQ-019 FSM states are IDLE, FILL, RUN, DRAIN and DONE.
REQ-020 IDLE -> FILL on the first accepted sample.
REQ-021 FILL -> RUN when the accepted-sample count reaches TAPS.
REQ-022 RUN -> DRAIN when the count reaches NUM_SAMPLES.
REQ-023 DRAIN -> DONE when no FFT is pending or busy.
REQ-024 fir_shift = data_valid combinationally in IDLE, FILL and RUN; it is 0 in DRAIN and DONE.
REQ-025 The sample counter is 11 bits and increments on each accepted sample; it saturates at NUM_SAMPLES.
REQ-026 fir_valid pulses one cycle after each accepted sample whose 1-based index is >= TAPS; latency is 1 cycle.
REQ-027 buf_wr equals fir_valid in the same cycle.
REQ-028 buf_addr increments after each write and wraps from FRAME_LEN-1 to 0.
REQ-029 A write at buf_addr = FRAME_LEN-1 completes a frame; buf_bank toggles on the following edge.
REQ-030 On frame completion with fft_busy=0 and nothing pending, fft_start pulses exactly one cycle later.
REQ-031 On frame completion with fft_busy=1, the frame is held pending.
REQ-032 A pending frame issues fft_start in the first cycle after fft_busy falls.
REQ-033 A frame completing while one is already pending is dropped and overrun is set; pending count never exceeds 1.
REQ-034 fft_valid pulses one cycle after each fft_done.
REQ-035 frame_cnt increments on each fft_done and saturates at 255.
REQ-036 fft_done arriving while no FFT was started is ignored and does not affect frame_cnt or fft_valid.
REQ-037 A trailing partial frame (fewer than FRAME_LEN writes at end of run) is discarded and never started.
REQ-038 Run end is defined as NUM_SAMPLES accepted samples. Expected frames = floor((NUM_SAMPLES-TAPS+1)/FRAME_LEN), which is 62 for the defaults.
REQ-039 done sets on the cycle the FSM enters DONE and holds until reset.
REQ-040 data_valid in DRAIN or DONE is ignored; no counter or output changes.
REQ-041 Simultaneous frame completion and fft_done: the done is processed first, so the new frame starts without pending if fft_busy=0.

Reset
REQ-042 On rst, all outputs are driven to 0, the FSM enters IDLE, and all counters, the pending flag and buf_bank clear.
REQ-043 rst asserted mid-run aborts immediately; a pending frame is lost and no fft_start is issued after rst falls until a new frame completes.

Verification
REQ-044 Defaults; 31 samples: no fir_valid. 32nd sample: fir_valid high one cycle later, with buf_wr=1 and buf_addr=0.
REQ-045 Defaults; 1024 back-to-back samples; fft_busy=0; fft_done two cycles after each fft_start. Required: 62 fft_start pulses, frame_cnt=62, done=1, overrun=0, and a final buf_addr of 1 (the partial frame is discarded).
REQ-046 fft_busy held high across one completion, released 5 cycles later. Required: fft_start exactly 1 cycle after fft_busy falls; overrun=0.
REQ-047 fft_busy held high across two completions. Required: overrun=1 and exactly one fft_start after release.
REQ-048 rst asserted after 100 samples. Required: all outputs are 0 next cycle. After restart, fir_valid first appears after the 32nd new sample.
REQ-049 data_valid pulsed in DONE. Required: no change to fir_valid, buf_addr, frame_cnt or done.
